// File: rtl/dfi_rd_scheduler.sv
`default_nettype none
// dfi_rd_scheduler: DDR5 DFI read sequencer (1:1 ratio, phase 0). It issues the
// two-cycle READ command, schedules rddata_en and checks that the read data returns.
module dfi_rd_scheduler #(
    parameter int TRDDATA_EN = 2,
    parameter int BURST_CYC  = 8,
    parameter int MAX_OUTST  = 4,
    parameter int TIMEOUT    = 64,
    parameter int DEV_W      = 4
) (
    input  logic                           dfi_clk,
    input  logic                           reset_n_i,
    input  logic                           en_i,
    input  logic                           err_clr_i,
    input  logic                           rd_valid_i,
    input  logic [22:0]                    rd_ca_i,
    output logic                           rd_ready_o,
    output logic                           dfi_cs_p0,
    output logic [13:0]                    dfi_address_p0,
    output logic                           dfi_rddata_en_p0,
    input  logic                           dfi_rddata_valid_w0,
    input  logic [2*DEV_W-1:0]             dfi_rddata_w0,
    output logic [2*DEV_W-1:0]             rd_data_o,
    output logic                           rd_data_vld_o,
    output logic                           rd_done_o,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                           err_unexp_o,
    output logic                           err_timeout_o
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int BW = $clog2(BURST_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTST);
    localparam logic [BW-1:0] BURST_C = BW'(BURST_CYC);
    localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD1 = 2'd1,
        CMD2 = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    live;
    logic [22:0]             ca;
    logic [BW-1:0]           space;
    logic [TRDDATA_EN-1:0]   issue_sr;
    logic [BW-1:0]           burst_cnt;
    logic [BW-1:0]           beat;
    logic [OW-1:0]           outst;
    logic [TW-1:0]           tmo_cnt;
    logic                    handshake;
    logic                    inc;
    logic                    expect_beat;
    logic                    last_beat;
    logic                    set_timeout;
    logic                    set_unexp;

    // live keeps ready low while reset is asserted and for the first cycle after release
    assign rd_ready_o  = live && (state == IDLE) && en_i && (space == '0) && (outst < MAX_O);
    assign handshake   = rd_valid_i && rd_ready_o;
    assign inc         = (state == CMD1);
    assign expect_beat = dfi_rddata_valid_w0 && (outst != '0);
    assign last_beat   = expect_beat && (beat == BURST_C - BW'(1));
    assign set_unexp   = dfi_rddata_valid_w0 && (outst == '0);
    assign set_timeout = !dfi_rddata_valid_w0 && (outst != '0) && (tmo_cnt == TMO_C - TW'(1));

    assign dfi_rddata_en_p0 = (burst_cnt != '0);
    assign outst_o          = outst;

    always_comb begin
        state_nxt      = state;
        dfi_cs_p0      = 1'b1;
        dfi_address_p0 = '0;
        case (state)
            IDLE: if (handshake) state_nxt = CMD1;
            CMD1: begin
                dfi_cs_p0      = 1'b0;
                dfi_address_p0 = {ca[8:0], 5'b11101};
                state_nxt      = CMD2;
            end
            CMD2: begin
                dfi_address_p0 = ca[22:9];
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge dfi_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= IDLE;
            live          <= 1'b0;
            ca            <= '0;
            space         <= '0;
            issue_sr      <= '0;
            burst_cnt     <= '0;
            beat          <= '0;
            outst         <= '0;
            tmo_cnt       <= '0;
            rd_data_o     <= '0;
            rd_data_vld_o <= 1'b0;
            rd_done_o     <= 1'b0;
            err_unexp_o   <= 1'b0;
            err_timeout_o <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            if (handshake) ca <= rd_ca_i;

            if (handshake)          space <= BURST_C - BW'(1);
            else if (space != '0)   space <= space - BW'(1);

            // The tap fires one cycle early so the registered counter lines up with T+TRDDATA_EN
            issue_sr <= (issue_sr << 1) | TRDDATA_EN'(handshake);
            if (issue_sr[TRDDATA_EN-1]) burst_cnt <= BURST_C;
            else if (burst_cnt != '0)   burst_cnt <= burst_cnt - BW'(1);

            if (last_beat)        beat <= '0;
            else if (expect_beat) beat <= beat + BW'(1);

            case ({inc, last_beat})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase

            if (dfi_rddata_valid_w0 || (outst == '0)) tmo_cnt <= '0;
            else if (tmo_cnt != TMO_C)                tmo_cnt <= tmo_cnt + TW'(1);

            rd_data_o     <= dfi_rddata_w0;
            rd_data_vld_o <= expect_beat;
            rd_done_o     <= last_beat;

            err_unexp_o   <= set_unexp   || (err_unexp_o   && !err_clr_i);
            err_timeout_o <= set_timeout || (err_timeout_o && !err_clr_i);
        end
    end

endmodule
`default_nettype wire
